// File: rtl/stream_cipher_pkg.sv
// Shared definitions for the stream cipher datapath.
//   interface_state_t  : states of the user-facing interface FSM
//   OUT_HOLD_WIDTH     : default result word width for output_hold_fifo
//   OUT_HOLD_DEPTH     : default number of held result words
//   out_hold_count_w() : width of a counter that must hold 0..depth
package stream_cipher_pkg;

    typedef enum logic [1:0] {
        IF_IDLE,
        IF_LOAD,
        IF_RUN,
        IF_OUTPUT
    } interface_state_t;

    localparam int OUT_HOLD_WIDTH = 8;
    localparam int OUT_HOLD_DEPTH = 4;

    // A count of held entries ranges over 0..depth inclusive, hence depth+1.
    function automatic int out_hold_count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ack_edge_detect.sv
// Rising-edge detector for a user-facing level input.
//   clk        : system clock
//   nrst       : synchronous active-low reset, clears the history flop
//   level_in   : level to watch
//   rise_pulse : high for the cycle in which level_in is 1 and was 0 last cycle
module ack_edge_detect (
    input  logic clk,
    input  logic nrst,
    input  logic level_in,
    output logic rise_pulse
);

    logic level_prev;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            level_prev <= 1'b0;
        end else begin
            level_prev <= level_in;
        end
    end

    assign rise_pulse = level_in && !level_prev;

endmodule

// File: rtl/output_hold_fifo.sv
// Holds result words from the encryption block in a DEPTH-entry circular
// buffer and presents the oldest one to the output mux until the interface
// FSM acknowledges it with a rising edge on read_ack.
//   clk, nrst       : clock, synchronous active-low reset
//   data_in         : result word, valid while data_in_pulse is high
//   data_in_pulse   : one-cycle push strobe
//   read_ack        : level, each rising edge pops one entry
//   flush           : synchronous clear of entries and flags (beats push/pop)
//   data_out        : oldest entry, 0 when empty
//   output_is_ready : at least one entry held
//   ready_pulse     : one-cycle strobe after each empty -> non-empty change
//   count           : number of held entries
//   overflow        : sticky, set when a pushed word cost data
// Build option: define OUTPUT_HOLD_OVERWRITE_EN to make a push into a full
// buffer (with no pop that cycle) overwrite the oldest entry instead of
// dropping the new word.
module output_hold_fifo
    import stream_cipher_pkg::*;
#(
    parameter int WIDTH = OUT_HOLD_WIDTH,
    parameter int DEPTH = OUT_HOLD_DEPTH
) (
    input  logic                                clk,
    input  logic                                nrst,
    input  logic [WIDTH-1:0]                    data_in,
    input  logic                                data_in_pulse,
    input  logic                                read_ack,
    input  logic                                flush,
    output logic [WIDTH-1:0]                    data_out,
    output logic                                output_is_ready,
    output logic                                ready_pulse,
    output logic [out_hold_count_w(DEPTH)-1:0]  count,
    output logic                                overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = out_hold_count_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_nxt;
    logic             overflow_q;
    logic             ready_pulse_q;

    logic ack_rise;
    logic empty;
    logic full;
    logic pop;
    logic push_ok;
    logic rd_adv;
    logic lost;

    ack_edge_detect u_ack_edge (
        .clk        (clk),
        .nrst       (nrst),
        .level_in   (read_ack),
        .rise_pulse (ack_rise)
    );

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == CW'(DEPTH));
        pop     = ack_rise && !empty;
        // A push into a full buffer only costs data when no pop frees a slot.
        lost    = data_in_pulse && full && !pop;
`ifdef OUTPUT_HOLD_OVERWRITE_EN
        // Overwrite mode: the write lands on the oldest slot (wr_ptr == rd_ptr
        // when full), so the read side must step past it.
        push_ok = data_in_pulse;
        rd_adv  = pop || lost;
`else
        push_ok = data_in_pulse && !lost;
        rd_adv  = pop;
`endif
        count_nxt = count_q;
        if (push_ok && !rd_adv) begin
            count_nxt = count_q + CW'(1);
        end else if (!push_ok && rd_adv) begin
            count_nxt = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst || flush) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            ready_pulse_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count_q       <= count_nxt;
            overflow_q    <= overflow_q || lost;
            ready_pulse_q <= empty && (count_nxt != '0);
        end
    end

    // Storage is not reset; the empty check masks stale contents.
    always_ff @(posedge clk) begin
        if (nrst && !flush && push_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    assign data_out        = empty ? '0 : mem[rd_ptr];
    assign output_is_ready = !empty;
    assign ready_pulse     = ready_pulse_q;
    assign count           = count_q;
    assign overflow        = overflow_q;

endmodule

// File: tb/tb_output_hold_fifo.sv
module tb_output_hold_fifo;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         nrst = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         data_in_pulse = 1'b0;
    logic         read_ack = 1'b0;
    logic         flush = 1'b0;
    logic [W-1:0] data_out;
    logic         output_is_ready;
    logic         ready_pulse;
    logic [2:0]   count;
    logic         overflow;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    output_hold_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk             (clk),
        .nrst            (nrst),
        .data_in         (data_in),
        .data_in_pulse   (data_in_pulse),
        .read_ack        (read_ack),
        .flush           (flush),
        .data_out        (data_out),
        .output_is_ready (output_is_ready),
        .ready_pulse     (ready_pulse),
        .count           (count),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of held words plus flags.
    logic [W-1:0] mq[$];
    bit m_ovf  = 1'b0;
    bit m_rp   = 1'b0;
    bit m_prev = 1'b0;

    always @(posedge clk) begin
        bit rise;
        bit was_empty;
        rise = read_ack && !m_prev;
        if (!nrst) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_rp   = 1'b0;
            m_prev = 1'b0;
        end else if (flush) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_rp   = 1'b0;
            m_prev = read_ack;
        end else begin
            was_empty = (mq.size() == 0);
            if (rise && !was_empty) void'(mq.pop_front());
            if (data_in_pulse) begin
                if (mq.size() < D) begin
                    mq.push_back(data_in);
                end else begin
                    m_ovf = 1'b1;
`ifdef OUTPUT_HOLD_OVERWRITE_EN
                    void'(mq.pop_front());
                    mq.push_back(data_in);
`endif
                end
            end
            m_rp   = was_empty && (mq.size() != 0);
            m_prev = read_ack;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc data_out", 32'(data_out), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
            chk("cyc count", 32'(count), 32'(mq.size()));
            chk("cyc output_is_ready", 32'(output_is_ready), 32'(mq.size() != 0));
            chk("cyc ready_pulse", 32'(ready_pulse), 32'(m_rp));
            chk("cyc overflow", 32'(overflow), 32'(m_ovf));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] d);
        data_in = d;
        data_in_pulse = 1'b1;
        tick();
        data_in_pulse = 1'b0;
    endtask

    task automatic ack();
        read_ack = 1'b1;
        tick();
        read_ack = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] last;
        // 1. reset then single word
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst count", 32'(count), 32'd0);
        chk("rst ready", 32'(output_is_ready), 32'd0);
        chk("rst data_out", 32'(data_out), 32'd0);
        chk("rst overflow", 32'(overflow), 32'd0);
        chk("rst ready_pulse", 32'(ready_pulse), 32'd0);
        nrst = 1'b1;
        push(8'hA5);
        chk("t1 ready", 32'(output_is_ready), 32'd1);
        chk("t1 ready_pulse", 32'(ready_pulse), 32'd1);
        chk("t1 data_out", 32'(data_out), 32'hA5);
        chk("t1 count", 32'(count), 32'd1);
        tick();
        chk("t1 ready_pulse drop", 32'(ready_pulse), 32'd0);
        read_ack = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("t1 count after hold", 32'(count), 32'd0);
        chk("t1 data_out after hold", 32'(data_out), 32'd0);
        read_ack = 1'b0;
        tick();

        // 2. order and wrap-around
        push(8'h11); push(8'h22); push(8'h33);
        chk("t2 head0", 32'(data_out), 32'h11);
        ack();
        chk("t2 head1", 32'(data_out), 32'h22);
        ack();
        chk("t2 head2", 32'(data_out), 32'h33);
        push(8'h44); push(8'h55); push(8'h66);
        chk("t2 count full", 32'(count), 32'd4);
        ack(); chk("t2 head3", 32'(data_out), 32'h44);
        ack(); chk("t2 head4", 32'(data_out), 32'h55);
        ack(); chk("t2 head5", 32'(data_out), 32'h66);
        ack(); chk("t2 empty", 32'(count), 32'd0);

        // 3. full / overflow
        for (int i = 1; i <= 5; i++) push(8'(i));
        chk("t3 count", 32'(count), 32'd4);
        chk("t3 overflow", 32'(overflow), 32'd1);
`ifdef OUTPUT_HOLD_OVERWRITE_EN
        chk("t3 head", 32'(data_out), 32'h02);
        for (int i = 2; i <= 5; i++) begin
            chk("t3 pop", 32'(data_out), 32'(i));
            ack();
        end
`else
        chk("t3 head", 32'(data_out), 32'h01);
        for (int i = 1; i <= 4; i++) begin
            chk("t3 pop", 32'(data_out), 32'(i));
            ack();
        end
`endif
        chk("t3 sticky", 32'(overflow), 32'd1);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("t3 flush ovf", 32'(overflow), 32'd0);

        // 4. simultaneous events
        push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
        data_in = 8'h77; data_in_pulse = 1'b1; read_ack = 1'b1;
        tick();
        data_in_pulse = 1'b0; read_ack = 1'b0;
        chk("t4 full ovf", 32'(overflow), 32'd0);
        chk("t4 full count", 32'(count), 32'd4);
        tick();
        last = '0;
        for (int i = 0; i < 4; i++) begin
            last = data_out;
            ack();
        end
        chk("t4 last word", 32'(last), 32'h77);
        chk("t4 drained", 32'(count), 32'd0);
        data_in = 8'h88; data_in_pulse = 1'b1; read_ack = 1'b1;
        tick();
        data_in_pulse = 1'b0; read_ack = 1'b0;
        chk("t4 empty count", 32'(count), 32'd1);
        chk("t4 empty data", 32'(data_out), 32'h88);
        tick();
        ack();

        // 5. flush and mid-operation reset
        for (int i = 0; i < 5; i++) push(8'hE0 + 8'(i));
        ack();
        chk("t5 pre count", 32'(count), 32'd3);
        chk("t5 pre ovf", 32'(overflow), 32'd1);
        data_in = 8'hF0; data_in_pulse = 1'b1; flush = 1'b1;
        tick();
        data_in_pulse = 1'b0; flush = 1'b0;
        chk("t5 flush count", 32'(count), 32'd0);
        chk("t5 flush ovf", 32'(overflow), 32'd0);
        chk("t5 flush ready", 32'(output_is_ready), 32'd0);
        push(8'hD1); push(8'hD2);
        chk("t5 refill", 32'(count), 32'd2);
        nrst = 1'b0; tick(); nrst = 1'b1;
        chk("t5 rst count", 32'(count), 32'd0);
        chk("t5 rst data", 32'(data_out), 32'd0);
        chk("t5 rst ready", 32'(output_is_ready), 32'd0);
        chk("t5 rst ovf", 32'(overflow), 32'd0);
        chk("t5 rst rp", 32'(ready_pulse), 32'd0);
        tick();
        tick();
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/output_hold_fifo.md
Name: output_hold_fifo

Overview:
Parametrised successor to the single-byte output holder. It captures one-cycle result pulses from the encryption block into a DEPTH-entry circular buffer. It presents the oldest entry to the output mux until the interface FSM acknowledges that the user has read it. It keeps results from being lost when the encryption block produces words faster than the user reads them.

Parameters:
- WIDTH, 8, data word width in bits (≥1).
- DEPTH, 4, number of held entries; power of two, ≥2.

Ports:
- clk  input  1  system clock.
- nrst  input  1  active-low reset, synchronous.
- data_in  input  WIDTH  result word from the encryption block.
- data_in_pulse  input  1  one-cycle strobe; data_in is valid in this cycle.
- read_ack  input  1  level from the interface FSM; high while the user reports "output read". Edge-detected internally.
- flush  input  1  synchronous clear of all entries and flags.
- data_out  output  WIDTH  head (oldest) entry to the output mux; 0 when empty.
- output_is_ready  output  1  level; high while ≥1 entry is held.
- ready_pulse  output  1  one-cycle strobe on each empty→non-empty transition.
- count  output  $clog2(DEPTH+1)  number of held entries.
- overflow  output  1  sticky; a push was lost while full.

Behaviour:
- Reset: clk and nrst form the only clock/reset pair. Reset is synchronous, active-low.
- On a rising clk with nrst=0:
  - all pointers and count clear to 0;
  - overflow=0, ready_pulse=0, output_is_ready=0, data_out=0;
  - the ack edge-detector history register clears to 0.
- Reset mid-operation discards all held entries. Storage contents need not be cleared.
- Storage: register array mem[DEPTH]. Write pointer wr_ptr and read pointer rd_ptr are each $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. count is tracked separately.
- Push: data_in_pulse=1 and not full → mem[wr_ptr]<=data_in, wr_ptr++, count++.
- Pop event: a rising edge of read_ack (read_ack=1 and previous read_ack=0).
  - Not empty → rd_ptr++, count--.
  - Empty → ignored.
  - Holding read_ack high pops exactly one entry.
- Latency:
  - data_in_pulse in cycle N → count, output_is_ready and data_out updated in cycle N+1.
  - read_ack rising in cycle N → next entry on data_out in cycle N+1.
- data_out is combinational from registered state: mem[rd_ptr] if count≠0, else 0.
- output_is_ready = (count≠0).
- ready_pulse is registered. It is 1 in the cycle after count goes from 0 to non-zero, otherwise 0.
- Simultaneous push and pop:
  - Not empty, not full → both occur; count unchanged.
  - Full → both occur; the pop frees the slot, so there is no overflow.
  - Empty → the push occurs and the pop is ignored; count=1.
- Full and push without pop → word dropped, overflow<=1. overflow stays 1 until flush or reset.
- flush=1 has priority over push and pop that cycle:
  - pointers, count and overflow clear;
  - ready_pulse=0.
- The ack edge history still samples read_ack during flush.

Optional Feature:
- Macro OUTPUT_HOLD_OVERWRITE_EN.
- Defined: push when full without pop overwrites the oldest entry.
  - mem[wr_ptr]<=data_in, wr_ptr++, rd_ptr++, count unchanged.
  - overflow<=1, still sticky, meaning "data was lost".
- Undefined: newest word dropped, as specified in Behaviour.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package stream_cipher_pkg already holds interface_state_t. Add to it:
  - the parameter defaults OUT_HOLD_WIDTH=8 and OUT_HOLD_DEPTH=4;
  - a count-width helper function.
- One sub-module: ack_edge_detect.
  - Ports: clk, nrst, level_in, rise_pulse.
  - One history flop, synchronous active-low reset to 0.
  - Reusable for other user-facing level inputs.

Test Plan (WIDTH=8, DEPTH=4):
1. Reset then single word:
   - Stimulus: nrst low 2 cycles, then pulse data_in=8'hA5.
   - Next cycle: output_is_ready=1, ready_pulse=1 for one cycle, data_out=8'hA5, count=1.
   - Then raise read_ack and hold it 5 cycles: count=0, data_out=0, exactly one pop.
2. Order and wrap-around:
   - Stimulus: push 11,22,33 and pop 2; push 44,55,66 and pop all.
   - data_out sequence is 11,22,33,44,55,66 across the pointer wrap.
   - ready_pulse fires only on empty→non-empty transitions.
3. Full/overflow, default build:
   - Stimulus: push 01..05 without acks.
   - count=4, overflow=1, data_out=01.
   - Popping all yields 01,02,03,04.
   - With OUTPUT_HOLD_OVERWRITE_EN: data_out=02 after the 5th push; pops yield 02..05.
4. Simultaneous events:
   - Full plus push 77 and ack rise in the same cycle: overflow stays 0, count=4, 77 is the last word read.
   - Empty plus push 88 and ack rise in the same cycle: count=1, data_out=88.
5. Flush and mid-operation reset:
   - Stimulus: with 3 entries and overflow=1, assert flush together with a push.
   - Next cycle: count=0, overflow=0, output_is_ready=0.
   - Stimulus: refill 2 entries, then drop nrst for 1 cycle.
   - Result: all outputs return to their reset values.
